// File: rtl/joybus_poll_scheduler_if.sv
// Command/response handshake between the poll scheduler and the bit-level joybus PHY.
interface joybus_poll_scheduler_if;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_is_poll;
  logic cmd_rumble;
  logic rsp_done;
  logic rsp_ok;

  modport master (
    output cmd_valid, cmd_is_poll, cmd_rumble,
    input  cmd_ready, rsp_done, rsp_ok
  );

  modport slave (
    input  cmd_valid, cmd_is_poll, cmd_rumble,
    output cmd_ready, rsp_done, rsp_ok
  );
endinterface

// File: rtl/joybus_poll_scheduler.sv
// GameCube joybus sequencer: probes until a controller answers, then polls on a fixed cadence,
// tracking failures, disconnects and re-probe backoff.
//
// state       | meaning
// IDLE        | scheduling disabled, connected held
// PROBE_REQ   | probe command offered to the PHY
// PROBE_WAIT  | waiting for probe response or timeout
// PERIOD_WAIT | connected, counting down to the next poll
// POLL_REQ    | poll command offered to the PHY
// POLL_WAIT   | waiting for poll response or timeout
// BACKOFF     | idle pause before re-probing
module joybus_poll_scheduler #(
  parameter int unsigned POLL_PERIOD_US  = 16000,
  parameter int unsigned RESP_TIMEOUT_US = 400,
  parameter int unsigned MAX_FAILS       = 3,
  parameter int unsigned BACKOFF_US      = 1000
) (
  input  logic                           usClock,
  input  logic                           Reset,
  input  logic                           enable,
  input  logic                           rumble_req,
  joybus_poll_scheduler_if.master        bus,
  output logic                           connected,
  output logic                           poll_strobe,
  output logic                           disconnect,
  output logic [1:0]                     fail_count,
  output logic [2:0]                     state_dbg
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PROBE_REQ   = 3'd1,
    PROBE_WAIT  = 3'd2,
    PERIOD_WAIT = 3'd3,
    POLL_REQ    = 3'd4,
    POLL_WAIT   = 3'd5,
    BACKOFF     = 3'd6
  } state_t;

  // Timers are down-counters that expire at zero. The poll-to-poll load is one shorter than
  // the probe-to-poll load because it is taken in the accept cycle itself.
  localparam logic [15:0] PER_FIRST = 16'(POLL_PERIOD_US - 1);
  localparam logic [15:0] PER_NEXT  = 16'(POLL_PERIOD_US - 2);
  localparam logic [15:0] TMR_RESP  = 16'(RESP_TIMEOUT_US - 1);
  localparam logic [15:0] TMR_BACK  = 16'(BACKOFF_US - 1);
  localparam logic [1:0]  FAIL_LAST = 2'(MAX_FAILS - 1);

  state_t      state, state_nxt;
  logic [15:0] per, per_nxt;
  logic [15:0] tmr, tmr_nxt;
  logic        connected_nxt;
  logic [1:0]  fail_nxt;
  logic        rumble_q, rumble_nxt;
  logic        disc_nxt;
  logic        accept, rsp_good, rsp_bad, tmr_tc, per_tc;

  assign accept   = bus.cmd_valid & bus.cmd_ready;
  assign rsp_good = bus.rsp_done & bus.rsp_ok;
  assign rsp_bad  = bus.rsp_done & ~bus.rsp_ok;
  assign tmr_tc   = (tmr == 16'd0);
  assign per_tc   = (per == 16'd0);

  assign bus.cmd_valid   = (state == PROBE_REQ) || (state == POLL_REQ);
  assign bus.cmd_is_poll = (state == POLL_REQ);
  assign bus.cmd_rumble  = rumble_q;
  assign poll_strobe     = ~Reset && (state == POLL_WAIT) && rsp_good;
  assign state_dbg       = state;

  always_comb begin
    state_nxt     = state;
    per_nxt       = per_tc ? 16'd0 : per - 16'd1;
    tmr_nxt       = tmr_tc ? 16'd0 : tmr - 16'd1;
    connected_nxt = connected;
    fail_nxt      = fail_count;
    rumble_nxt    = rumble_q;
    disc_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_nxt = connected ? POLL_REQ : PROBE_REQ;
      end
      PROBE_REQ: begin
        if (accept) begin
          tmr_nxt   = TMR_RESP;
          state_nxt = PROBE_WAIT;
        end else if (!enable) begin
          state_nxt = IDLE;
        end
      end
      PROBE_WAIT: begin
        // A response arriving in the expiry cycle still counts.
        if (rsp_good) begin
          connected_nxt = 1'b1;
          fail_nxt      = 2'd0;
          per_nxt       = PER_FIRST;
          state_nxt     = enable ? PERIOD_WAIT : IDLE;
        end else if (rsp_bad || tmr_tc) begin
          tmr_nxt   = TMR_BACK;
          state_nxt = enable ? BACKOFF : IDLE;
        end
      end
      PERIOD_WAIT: begin
        if (!enable)     state_nxt = IDLE;
        else if (per_tc) state_nxt = POLL_REQ;
      end
      POLL_REQ: begin
        if (accept) begin
          rumble_nxt = rumble_req;
          per_nxt    = PER_NEXT;
          tmr_nxt    = TMR_RESP;
          state_nxt  = POLL_WAIT;
        end else if (!enable) begin
          state_nxt = IDLE;
        end
      end
      POLL_WAIT: begin
        if (rsp_good) begin
          fail_nxt  = 2'd0;
          state_nxt = enable ? PERIOD_WAIT : IDLE;
        end else if (rsp_bad || tmr_tc) begin
          if (fail_count >= FAIL_LAST) begin
            connected_nxt = 1'b0;
            disc_nxt      = 1'b1;
            fail_nxt      = 2'd0;
            rumble_nxt    = 1'b0;
            tmr_nxt       = TMR_BACK;
            state_nxt     = enable ? BACKOFF : IDLE;
          end else begin
            fail_nxt  = fail_count + 2'd1;
            state_nxt = enable ? PERIOD_WAIT : IDLE;
          end
        end
      end
      BACKOFF: begin
        if (!enable)     state_nxt = IDLE;
        else if (tmr_tc) state_nxt = PROBE_REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge usClock) begin
    if (Reset) begin
      state      <= IDLE;
      per        <= 16'd0;
      tmr        <= 16'd0;
      connected  <= 1'b0;
      fail_count <= 2'd0;
      rumble_q   <= 1'b0;
      disconnect <= 1'b0;
    end else begin
      state      <= state_nxt;
      per        <= per_nxt;
      tmr        <= tmr_nxt;
      connected  <= connected_nxt;
      fail_count <= fail_nxt;
      rumble_q   <= rumble_nxt;
      disconnect <= disc_nxt;
    end
  end

endmodule

// File: tb/tb_joybus_poll_scheduler.sv
// Bench for joybus_poll_scheduler: acts as the PHY and predicts each transaction's outcome.
module tb_joybus_poll_scheduler;
  localparam int PER = 50;
  localparam int TO  = 10;
  localparam int MF  = 3;
  localparam int BO  = 5;

  logic       usClock = 1'b0;
  logic       Reset;
  logic       enable;
  logic       rumble_req;
  logic       connected;
  logic       poll_strobe;
  logic       disconnect;
  logic [1:0] fail_count;
  logic [2:0] state_dbg;

  joybus_poll_scheduler_if jb ();

  joybus_poll_scheduler #(
    .POLL_PERIOD_US (PER),
    .RESP_TIMEOUT_US(TO),
    .MAX_FAILS      (MF),
    .BACKOFF_US     (BO)
  ) dut (
    .usClock    (usClock),
    .Reset      (Reset),
    .enable     (enable),
    .rumble_req (rumble_req),
    .bus        (jb),
    .connected  (connected),
    .poll_strobe(poll_strobe),
    .disconnect (disconnect),
    .fail_count (fail_count),
    .state_dbg  (state_dbg)
  );

  always #5 usClock = ~usClock;

  int cyc = 0;
  always @(posedge usClock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: transaction-level expectations
  int exp_req;        // cycle in which the next command request must appear
  bit m_conn  = 0;
  int m_fails = 0;
  bit m_rum   = 0;
  int s_cyc   = -1;   // cycle expected to carry poll_strobe
  int d_cyc   = -1;   // cycle expected to carry disconnect

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic enter_cycle(input logic rdy, input logic done, input logic ok, input logic rum);
    @(negedge usClock);
    jb.cmd_ready = rdy;
    jb.rsp_done  = done;
    jb.rsp_ok    = ok;
    rumble_req   = rum;
    #1;
  endtask

  task automatic obs_chk(input logic exp_valid);
    check_val("cmd_valid", jb.cmd_valid, exp_valid);
    check_val("poll_strobe", poll_strobe, cyc == s_cyc);
    check_val("disconnect", disconnect, cyc == d_cyc);
  endtask

  // kind: 0 = good response after d cycles, 1 = bad response after d cycles, 2 = no response
  task automatic do_txn(input bit is_poll, input int stall, input int kind, input int d,
                        input bit rum, input bit drop_en);
    int acc;
    int e;
    while (cyc + 1 < exp_req) begin
      enter_cycle(0, 0, 1'($urandom), 1'($urandom));
      obs_chk(0);
    end
    for (int i = 0; i <= stall; i++) begin
      enter_cycle(i == stall, 0, 0, (i == stall) ? rum : 1'($urandom));
      obs_chk(1);
      check_val("cmd_is_poll", jb.cmd_is_poll, is_poll);
    end
    acc = cyc;
    if (is_poll) m_rum = rum;
    e = (kind == 2) ? acc + TO : acc + d;
    if (is_poll && kind == 0) s_cyc = e;
    if (drop_en) enable = 0;
    while (cyc < e) begin
      enter_cycle(0, (kind != 2) && (cyc + 1 == e), (kind == 0) ? 1'b1 : 1'b0, 1'($urandom));
      obs_chk(0);
      if (cyc == acc + 1) check_val("cmd_rumble", jb.cmd_rumble, m_rum);
    end
    if (!is_poll) begin
      if (kind == 0) begin
        m_conn  = 1;
        m_fails = 0;
        exp_req = e + PER + 1;
      end else begin
        exp_req = e + 1 + BO;
      end
    end else if (kind == 0) begin
      m_fails = 0;
      exp_req = acc + PER;
    end else if (m_fails < MF - 1) begin
      m_fails++;
      exp_req = acc + PER;
    end else begin
      m_conn  = 0;
      m_fails = 0;
      m_rum   = 0;
      d_cyc   = e + 1;
      exp_req = e + 1 + BO;
    end
    enter_cycle(0, 0, 1'($urandom), 1'($urandom));
    obs_chk(0);
    check_val("connected", connected, m_conn);
    check_val("fail_count", fail_count, m_fails);
    check_val("cmd_rumble_hold", jb.cmd_rumble, m_rum);
    check_val("state_dbg", state_dbg, drop_en ? 0 : (m_conn ? 3 : 6));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset        = 1;
    enable       = 0;
    rumble_req   = 0;
    jb.cmd_ready = 0;
    jb.rsp_done  = 0;
    jb.rsp_ok    = 0;
    repeat (3) @(negedge usClock);
    #1;
    check_val("rst_cmd_valid", jb.cmd_valid, 0);
    check_val("rst_cmd_is_poll", jb.cmd_is_poll, 0);
    check_val("rst_cmd_rumble", jb.cmd_rumble, 0);
    check_val("rst_connected", connected, 0);
    check_val("rst_poll_strobe", poll_strobe, 0);
    check_val("rst_disconnect", disconnect, 0);
    check_val("rst_fail_count", fail_count, 0);
    check_val("rst_state", state_dbg, 0);
    Reset   = 0;
    enable  = 1;
    exp_req = cyc + 1;

    // connect, then three back-to-back polls
    do_txn(0, 0, 0, 4, 0, 0);
    repeat (3) do_txn(1, 0, 0, 3, 0, 0);
    // PHY stall during a poll request
    do_txn(1, 7, 0, 5, 0, 0);
    do_txn(1, 0, 0, 2, 0, 0);
    // two timeouts, recovery, then three timeouts into disconnect
    repeat (2) do_txn(1, 0, 2, 1, 0, 0);
    do_txn(1, 0, 0, 6, 0, 0);
    repeat (3) do_txn(1, 0, 2, 1, 0, 0);
    // probe silence, bad probe, then probe answered on the expiry cycle
    do_txn(0, 0, 2, 1, 0, 0);
    do_txn(0, 0, 1, 3, 0, 0);
    do_txn(0, 0, 0, TO, 0, 0);
    // rumble sampled per accept; good response coinciding with timeout
    do_txn(1, 0, 0, TO, 1, 0);
    do_txn(1, 0, 0, 4, 0, 0);
    do_txn(1, 0, 1, 2, 1, 0);

    for (int n = 0; n < 120; n++) begin
      int k;
      int kind;
      int stall;
      k     = $urandom_range(0, 9);
      kind  = (k < 6) ? 0 : ((k < 8) ? 2 : 1);
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      do_txn(m_conn, stall, kind, $urandom_range(1, TO), 1'($urandom), 0);
    end

    if (!m_conn) do_txn(0, 0, 0, 2, 0, 0);
    // disable during POLL_WAIT: transaction completes, then IDLE with connected held
    do_txn(1, 0, 0, 3, 1, 1);
    enable = 1;
    enter_cycle(0, 0, 0, 0);
    check_val("reen_poll_valid", jb.cmd_valid, 1);
    check_val("reen_poll_kind", jb.cmd_is_poll, 1);
    enable = 0;
    enter_cycle(0, 0, 0, 0);
    check_val("req_drop_valid", jb.cmd_valid, 0);
    check_val("req_drop_state", state_dbg, 0);
    check_val("req_drop_conn", connected, 1);
    enable  = 1;
    exp_req = cyc + 1;
    do_txn(1, 0, 0, 4, 1, 0);

    // reset in the middle of POLL_WAIT, with a late response afterwards
    while (cyc + 1 < exp_req) begin
      enter_cycle(0, 0, 0, 0);
      obs_chk(0);
    end
    enter_cycle(1, 0, 0, 1);
    obs_chk(1);
    enter_cycle(0, 0, 0, 0);
    check_val("pre_rst_state", state_dbg, 5);
    Reset  = 1;
    enable = 0;
    @(negedge usClock);
    Reset       = 0;
    jb.rsp_done = 1;
    jb.rsp_ok   = 1;
    #1;
    check_val("mid_rst_strobe", poll_strobe, 0);
    check_val("mid_rst_valid", jb.cmd_valid, 0);
    check_val("mid_rst_rumble", jb.cmd_rumble, 0);
    check_val("mid_rst_conn", connected, 0);
    check_val("mid_rst_disc", disconnect, 0);
    check_val("mid_rst_fails", fail_count, 0);
    check_val("mid_rst_state", state_dbg, 0);
    m_conn  = 0;
    m_fails = 0;
    m_rum   = 0;
    enter_cycle(0, 0, 0, 0);
    check_val("post_rst_state", state_dbg, 0);
    enable  = 1;
    exp_req = cyc + 1;
    do_txn(0, 0, 0, 3, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
